decode_pipe_ctrl: RTL and testbench
===================================

Name: decode_pipe_ctrl

Overview:
- Registered instruction-decode stage with valid/ready handshake on both sides.
- Decodes opcode and fields of the 32-bit instruction word into control flags, register addresses and sign-extended immediate; holds them in an output register (ID/EX boundary).
- Detects load-use hazards against the instruction held in the output register and inserts one bubble.
- Supports synchronous flush and keeps saturating stall/illegal-opcode counters for debug.

Parameters:
- INSN_W, 32, instruction width. Field positions: opcode [INSN_W-1 -: OPC_W], rd next below it, rs below rd, rt below rs, shamt [11:7], aluop [6:2], imm [IMM_W-1:0].
- OPC_W, 5, opcode width.
- REG_W, 5, register-address width.
- IMM_W, 17, immediate width; sign-extended to INSN_W.
- CNT_W, 16, width of each debug counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream instruction valid
- in_insn  in  INSN_W  upstream instruction word
- in_ready  out  1  stage accepts in_insn this cycle
- out_valid  out  1  output register holds a valid decoded instruction
- out_ready  in  1  downstream accepts output this cycle
- out_is_alu / out_is_addi / out_is_sw / out_is_lw  out  1 each  opcode flags
- out_is_illegal  out  1  opcode not in the supported set
- out_wren  out  1  instruction writes register rd
- out_rd, out_rs, out_rt  out  REG_W each  register fields
- out_shamt, out_aluop  out  5 each  R-type fields
- out_imm_sx  out  INSN_W  sign-extended immediate
- stall_cnt  out  CNT_W  load-use bubbles inserted (saturating)
- illegal_cnt  out  CNT_W  illegal instructions accepted (saturating)

Behaviour:
- Opcodes: alu=00000, addi=00101, sw=00111, lw=01000. Any other opcode sets is_illegal with all four flags 0.
- wren = (alu|addi|lw) & (rd != 0); it is 0 for sw and illegal.
- Source registers read by the incoming instruction:
  - alu: rs, rt
  - addi, lw: rs
  - sw: rs, rd
  - illegal: none
- hazard = out_valid & out_is_lw & (out_rd != 0) & in_valid & (incoming source == out_rd).
- adv = ~out_valid | out_ready.
- in_ready = adv & ~hazard & ~flush. Combinational; no combinational path from in_insn except through hazard.
- Accept = in_valid & in_ready. Latency is 1 cycle: the decoded word appears on out_* the cycle after acceptance.
- Output register update, in priority order:
  - reset: all out_* = 0, counters = 0.
  - else if flush: out_valid <= 0; the incoming word is dropped, never stored.
  - else if adv: if accept, load decoded fields and out_valid <= 1; otherwise out_valid <= 0 (bubble).
  - else hold all out_* unchanged (backpressure). This register is the stage's only storage; there is no skid buffer.
- Load-use: when hazard & adv, the output advances to a bubble and in_ready=0. The next cycle out_valid=0, so no hazard, and the instruction is accepted. Exactly one bubble per lw→dependent pair. stall_cnt increments once per cycle in which hazard & adv & ~flush.
- hazard while ~adv: in_ready is already 0 and stall_cnt does not increment.
- illegal_cnt increments on accept of an illegal opcode. Illegal words are still passed downstream (out_valid=1, wren=0) for trap handling.
- Counters saturate at all-ones and never wrap.
- out_* data fields are don't-care when out_valid=0 but must stay stable while out_valid=1 & ~out_ready.
- Reset or flush mid-stall: any pending bubble/hazard state is discarded; there is no internal state beyond the output register and counters.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, in_ready=0 is not required (in_ready=adv=1 is allowed); counters=0.
- ALU decode: in_insn=0x00C22000, out_ready=1 → next cycle out_is_alu=1, rd=3, rs=1, rt=2, wren=1, illegal=0.
- addi sign-extend: in_insn=0x2843FFFF → out_is_addi=1, rd=1, rs=1, out_imm_sx=0xFFFFFFFF, wren=1.
- Load-use: 0x41020008 (lw $4) then 0x01480000 (add $5,$4,$0), out_ready=1 → add held one cycle (in_ready=0), one bubble cycle with out_valid=0, add appears 2 cycles after lw; stall_cnt=1. Repeat with lw rd=0 → no bubble.
- Backpressure and flush: out_ready=0 for 3 cycles → out_* stable, in_ready=0; flush with in_valid=1 → out_valid=0 next cycle and the word is dropped.
- Illegal: in_insn=0xF8000000 → out_is_illegal=1, wren=0, out_valid=1, illegal_cnt=1; with CNT_W=2, 5 illegal words → illegal_cnt=3.

Source files
------------

// File: rtl/decode_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// decode_pipe_ctrl
//
// Registered instruction-decode stage sitting on the ID/EX boundary.
// An incoming instruction word is decoded combinationally and, when the
// stage accepts it, the decoded control flags, register fields and
// sign-extended immediate are captured in a single output register.
// Load-use hazards against the instruction currently held in that register
// are resolved by inserting exactly one bubble. Two saturating debug
// counters record inserted bubbles and accepted illegal opcodes.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until that edge. On the input side, in_ready never depends on
// in_insn except through the hazard compare.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   flush           synchronous flush: empties the stage, drops the input
//   in_valid        upstream instruction valid
//   in_insn         upstream instruction word
//   in_ready        stage accepts in_insn this cycle
//   out_valid       output register holds a decoded instruction
//   out_ready       downstream accepts the output this cycle
//   out_is_alu/addi/sw/lw   opcode flags
//   out_is_illegal  opcode not in the supported set
//   out_wren        instruction writes register rd
//   out_rd/rs/rt    register address fields
//   out_shamt       shift amount field
//   out_aluop       ALU sub-operation field
//   out_imm_sx      immediate, sign-extended to INSN_W
//   stall_cnt       load-use bubbles inserted (saturating)
//   illegal_cnt     illegal instructions accepted (saturating)
// ---------------------------------------------------------------------------
module decode_pipe_ctrl #(
    parameter int INSN_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    input  logic [INSN_W-1:0] in_insn,
    output logic              in_ready,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_alu,
    output logic              out_is_addi,
    output logic              out_is_sw,
    output logic              out_is_lw,
    output logic              out_is_illegal,
    output logic              out_wren,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [4:0]        out_shamt,
    output logic [4:0]        out_aluop,
    output logic [INSN_W-1:0] out_imm_sx,

    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    // -----------------------------------------------------------------------
    // Field layout: opcode at the top, then rd, rs, rt packed downwards.
    // -----------------------------------------------------------------------
    localparam int OPC_LSB = INSN_W - OPC_W;
    localparam int RD_LSB  = OPC_LSB - REG_W;
    localparam int RS_LSB  = RD_LSB - REG_W;
    localparam int RT_LSB  = RS_LSB - REG_W;

    localparam logic [OPC_W-1:0] OPC_ALU  = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OPC_SW   = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OPC_LW   = OPC_W'(5'b01000);

    // -----------------------------------------------------------------------
    // Output register (the stage's only storage besides the counters)
    // -----------------------------------------------------------------------
    logic              r_valid;
    logic              r_is_alu;
    logic              r_is_addi;
    logic              r_is_sw;
    logic              r_is_lw;
    logic              r_is_illegal;
    logic              r_wren;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [4:0]        r_shamt;
    logic [4:0]        r_aluop;
    logic [INSN_W-1:0] r_imm_sx;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_illegal_cnt;

    // -----------------------------------------------------------------------
    // Combinational decode of the incoming word
    // -----------------------------------------------------------------------
    logic [OPC_W-1:0]  w_opc;
    logic [REG_W-1:0]  w_rd;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [4:0]        w_shamt;
    logic [4:0]        w_aluop;
    logic [INSN_W-1:0] w_imm_sx;

    logic w_dec_alu;
    logic w_dec_addi;
    logic w_dec_sw;
    logic w_dec_lw;
    logic w_dec_illegal;
    logic w_dec_wren;

    always_comb begin
        w_opc    = in_insn[INSN_W-1 -: OPC_W];
        w_rd     = in_insn[RD_LSB +: REG_W];
        w_rs     = in_insn[RS_LSB +: REG_W];
        w_rt     = in_insn[RT_LSB +: REG_W];
        w_shamt  = in_insn[11:7];
        w_aluop  = in_insn[6:2];
        w_imm_sx = {{(INSN_W-IMM_W){in_insn[IMM_W-1]}}, in_insn[IMM_W-1:0]};

        w_dec_alu     = (w_opc == OPC_ALU);
        w_dec_addi    = (w_opc == OPC_ADDI);
        w_dec_sw      = (w_opc == OPC_SW);
        w_dec_lw      = (w_opc == OPC_LW);
        w_dec_illegal = ~(w_dec_alu | w_dec_addi | w_dec_sw | w_dec_lw);

        // Writes to r0 are architecturally discarded, so they never count
        // as a register write.
        w_dec_wren = (w_dec_alu | w_dec_addi | w_dec_lw) & (w_rd != '0);
    end

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    //
    // Only a valid lw with a non-zero destination can create a hazard. The
    // incoming instruction is compared on the registers it actually reads:
    // sw reads rd as its store-data source, illegal words read nothing.
    // -----------------------------------------------------------------------
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_hit_rd;
    logic w_src_hit;
    logic w_hazard;
    logic w_adv;
    logic w_in_ready;
    logic w_accept;
    logic w_stall_inc;
    logic w_illegal_inc;

    always_comb begin
        w_hit_rs = (w_rs == r_rd);
        w_hit_rt = (w_rt == r_rd);
        w_hit_rd = (w_rd == r_rd);

        w_src_hit = (w_dec_alu               & (w_hit_rs | w_hit_rt))
                  | ((w_dec_addi | w_dec_lw) &  w_hit_rs)
                  | (w_dec_sw                & (w_hit_rs | w_hit_rd));

        w_hazard = r_valid & r_is_lw & (r_rd != '0) & in_valid & w_src_hit;

        // The output register can take a new value when it is empty or
        // being drained this cycle.
        w_adv      = ~r_valid | out_ready;
        w_in_ready = w_adv & ~w_hazard & ~flush;
        w_accept   = in_valid & w_in_ready;

        // A bubble is only "inserted" when the register actually advances;
        // a hazard under backpressure costs nothing extra.
        w_stall_inc   = w_hazard & w_adv & ~flush;
        w_illegal_inc = w_accept & w_dec_illegal;
    end

    // -----------------------------------------------------------------------
    // Output register and debug counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_is_alu      <= 1'b0;
            r_is_addi     <= 1'b0;
            r_is_sw       <= 1'b0;
            r_is_lw       <= 1'b0;
            r_is_illegal  <= 1'b0;
            r_wren        <= 1'b0;
            r_rd          <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_shamt       <= '0;
            r_aluop       <= '0;
            r_imm_sx      <= '0;
            r_stall_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                // No accept while advancing means a bubble moves in. The
                // data fields are left as they were: they are don't-care
                // while r_valid is 0.
                r_valid <= w_accept;
                if (w_accept) begin
                    r_is_alu     <= w_dec_alu;
                    r_is_addi    <= w_dec_addi;
                    r_is_sw      <= w_dec_sw;
                    r_is_lw      <= w_dec_lw;
                    r_is_illegal <= w_dec_illegal;
                    r_wren       <= w_dec_wren;
                    r_rd         <= w_rd;
                    r_rs         <= w_rs;
                    r_rt         <= w_rt;
                    r_shamt      <= w_shamt;
                    r_aluop      <= w_aluop;
                    r_imm_sx     <= w_imm_sx;
                end
            end

            // Saturate at all-ones instead of wrapping.
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_illegal_inc && (r_illegal_cnt != '1)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign out_is_alu     = r_is_alu;
    assign out_is_addi    = r_is_addi;
    assign out_is_sw      = r_is_sw;
    assign out_is_lw      = r_is_lw;
    assign out_is_illegal = r_is_illegal;
    assign out_wren       = r_wren;
    assign out_rd         = r_rd;
    assign out_rs         = r_rs;
    assign out_rt         = r_rt;
    assign out_shamt      = r_shamt;
    assign out_aluop      = r_aluop;
    assign out_imm_sx     = r_imm_sx;
    assign stall_cnt      = r_stall_cnt;
    assign illegal_cnt    = r_illegal_cnt;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_ctrl
//
// Self-checking bench for decode_pipe_ctrl. A reference decoder turns each
// accepted word into an expected output vector pushed on exp_q; a monitor
// pops and compares whenever the output handshake completes. Scenario tasks
// add cycle-level checks for hazards, backpressure, flush and counters.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
// ---------------------------------------------------------------------------
module tb_decode_pipe_ctrl;

    localparam int EXP_W = 63;

    localparam logic [31:0] W_ALU    = 32'h00C2_2000; // add $3,$1,$2
    localparam logic [31:0] W_ADDI   = 32'h2843_FFFF; // addi $1,$1,-1
    localparam logic [31:0] W_LW4    = 32'h4102_0008; // lw $4,8($1)
    localparam logic [31:0] W_ADD54  = 32'h0148_0000; // add $5,$4,$0
    localparam logic [31:0] W_LW0    = 32'h4002_0008; // lw $0,8($1)
    localparam logic [31:0] W_ADD500 = 32'h0140_0000; // add $5,$0,$0
    localparam logic [31:0] W_SW4    = 32'h3900_0000; // sw $4,0($0)
    localparam logic [31:0] W_ILL    = 32'hF800_0000; // opcode 11111

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_insn = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic        out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal, out_wren;
    logic [4:0]  out_rd, out_rs, out_rt, out_shamt, out_aluop;
    logic [31:0] out_imm_sx;
    logic [15:0] stall_cnt, illegal_cnt;

    logic        in_ready2, out_valid2;
    logic        out_is_alu2, out_is_addi2, out_is_sw2, out_is_lw2, out_is_illegal2, out_wren2;
    logic [4:0]  out_rd2, out_rs2, out_rt2, out_shamt2, out_aluop2;
    logic [31:0] out_imm_sx2;
    logic [1:0]  stall_cnt2, illegal_cnt2;

    decode_pipe_ctrl u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_insn(in_insn), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_alu(out_is_alu), .out_is_addi(out_is_addi), .out_is_sw(out_is_sw),
        .out_is_lw(out_is_lw), .out_is_illegal(out_is_illegal), .out_wren(out_wren),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_shamt(out_shamt), .out_aluop(out_aluop), .out_imm_sx(out_imm_sx),
        .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
    );

    decode_pipe_ctrl #(.CNT_W(2)) u_dut_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_insn(in_insn), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_is_alu(out_is_alu2), .out_is_addi(out_is_addi2), .out_is_sw(out_is_sw2),
        .out_is_lw(out_is_lw2), .out_is_illegal(out_is_illegal2), .out_wren(out_wren2),
        .out_rd(out_rd2), .out_rs(out_rs2), .out_rt(out_rt2),
        .out_shamt(out_shamt2), .out_aluop(out_aluop2), .out_imm_sx(out_imm_sx2),
        .stall_cnt(stall_cnt2), .illegal_cnt(illegal_cnt2)
    );

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_illegal = 0;
    bit mon_en = 1'b0;

    function automatic bit is_illegal_opc(input logic [31:0] w);
        logic [4:0] opc;
        opc = w[31:27];
        return !(opc == 5'b00000 || opc == 5'b00101 || opc == 5'b00111 || opc == 5'b01000);
    endfunction

    function automatic logic [EXP_W-1:0] model(input logic [31:0] w);
        logic [4:0] opc;
        logic alu, addi, sw, lw, ill, wren;
        opc  = w[31:27];
        alu  = (opc == 5'b00000);
        addi = (opc == 5'b00101);
        sw   = (opc == 5'b00111);
        lw   = (opc == 5'b01000);
        ill  = is_illegal_opc(w);
        wren = (alu || addi || lw) && (w[26:22] != 5'd0);
        return {alu, addi, sw, lw, ill, wren, w[26:22], w[21:17], w[16:12],
                w[11:7], w[6:2], {{15{w[16]}}, w[16:0]}};
    endfunction

    logic [EXP_W-1:0] obs;
    assign obs = {out_is_alu, out_is_addi, out_is_sw, out_is_lw, out_is_illegal, out_wren,
                  out_rd, out_rs, out_rt, out_shamt, out_aluop, out_imm_sx};

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Output monitor: a transfer completes on the edge after this negedge.
    always @(negedge clock) begin
        if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got %h, expected nothing", obs);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %h, expected %h", obs, e);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] w, input bit rand_ready);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_insn  = w;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(model(w));
                if (is_illegal_opc(w)) exp_illegal++;
                done = 1'b1;
            end
            @(posedge clock); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: insn %h not accepted within 60 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    // scenario tasks
    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_insn = W_ALU; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        checks++;
        if (stall_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", stall_cnt, illegal_cnt);
        end
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_alu_decode;
        out_ready = 1'b1;
        send(W_ALU, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_is_alu !== 1'b1 || out_is_illegal !== 1'b0 || out_wren !== 1'b1) begin
            errors++; $display("FAIL alu_flags: got v=%b alu=%b ill=%b wren=%b, required 1 1 0 1",
                               out_valid, out_is_alu, out_is_illegal, out_wren);
        end
        checks++;
        if (out_rd !== 5'd3 || out_rs !== 5'd1 || out_rt !== 5'd2) begin
            errors++; $display("FAIL alu_regs: got rd=%0d rs=%0d rt=%0d, required 3 1 2", out_rd, out_rs, out_rt);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_addi_sext;
        out_ready = 1'b1;
        send(W_ADDI, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_is_addi !== 1'b1 || out_rd !== 5'd1 || out_rs !== 5'd1 || out_wren !== 1'b1) begin
            errors++; $display("FAIL addi_fields: got addi=%b rd=%0d rs=%0d wren=%b, required 1 1 1 1",
                               out_is_addi, out_rd, out_rs, out_wren);
        end
        checks++;
        if (out_imm_sx !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL addi_imm: got %h, required ffffffff", out_imm_sx);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send(W_ILL, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_is_illegal !== 1'b1 || out_wren !== 1'b0) begin
            errors++; $display("FAIL illegal_flags: got v=%b ill=%b wren=%b, required 1 1 0",
                               out_valid, out_is_illegal, out_wren);
        end
        checks++;
        if (illegal_cnt !== 16'(exp_illegal)) begin
            errors++; $display("FAIL illegal_cnt_first: got %0d, required %0d", illegal_cnt, exp_illegal);
        end
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) send(W_ILL | 32'(i * 37), 1'b0);
        idle(1);
        @(negedge clock);
        checks++;
        if (illegal_cnt !== 16'(exp_illegal)) begin
            errors++; $display("FAIL illegal_cnt: got %0d, required %0d", illegal_cnt, exp_illegal);
        end
        checks++;
        if (illegal_cnt2 !== 2'(sat3(exp_illegal))) begin
            errors++; $display("FAIL illegal_cnt_sat: got %0d, required %0d", illegal_cnt2, sat3(exp_illegal));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_load_use;
        out_ready = 1'b1;
        send(W_LW4, 1'b0);
        in_insn = W_ADD54;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_hold: in_ready got %b, required 0", in_ready); end
        @(posedge clock); #1;
        exp_stall++;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_bubble: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        if (in_ready) exp_q.push_back(model(W_ADD54));
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5) begin
            errors++; $display("FAIL lu_dep_out: got v=%b rd=%0d, required 1 5", out_valid, out_rd);
        end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_stall_cnt: got %0d, required %0d", stall_cnt, exp_stall);
        end
        @(posedge clock); #1;

        // lw to r0 never stalls, even against a read of r0
        send(W_LW0, 1'b0);
        in_insn = W_ADD500;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_r0: in_ready got %b, required 1", in_ready); end
        if (in_ready) exp_q.push_back(model(W_ADD500));
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_r0_out: got v=%b stall=%0d, required 1 %0d", out_valid, stall_cnt, exp_stall);
        end
        @(posedge clock); #1;

        // sw reads rd as its data source
        send(W_LW4, 1'b0);
        in_insn = W_SW4;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_sw: in_ready got %b, required 0", in_ready); end
        @(posedge clock); #1;
        exp_stall++;
        send(W_SW4, 1'b0);
        idle(1);
        @(negedge clock);
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL lu_sw_stall_cnt: got %0d, required %0d", stall_cnt, exp_stall);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_hazard_backpressure;
        out_ready = 1'b0;
        send(W_LW4, 1'b0);
        in_insn = W_ADD54;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hz_bp_ready: got %b, required 0", in_ready); end
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL hz_bp_stall_cnt: got %0d, required %0d", stall_cnt, exp_stall);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        exp_stall++;
        send(W_ADD54, 1'b0);
        idle(1);
        @(negedge clock);
        checks++;
        if (stall_cnt !== 16'(exp_stall) || stall_cnt2 !== 2'(sat3(exp_stall))) begin
            errors++; $display("FAIL hz_release_stall_cnt: got %0d/%0d, required %0d/%0d",
                               stall_cnt, stall_cnt2, exp_stall, sat3(exp_stall));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(W_ALU, 1'b0);
        in_insn = W_ADDI;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || obs !== model(W_ALU) || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: got v=%b out=%h rdy=%b, required 1 %h 0",
                                   out_valid, obs, in_ready, model(W_ALU));
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        send(W_ADDI, 1'b0);
        drain();
    endtask

    task automatic test_flush;
        // flush an empty stage: the offered word is dropped
        out_ready = 1'b1;
        in_valid = 1'b1; in_insn = W_ADDI; flush = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", in_ready); end
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: out_valid got %b, required 0", out_valid); end
        @(posedge clock); #1;

        // flush a held output: it is discarded
        out_ready = 1'b0;
        send(W_ALU, 1'b0);
        in_insn = W_ADDI; flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: out_valid got %b, required 0", out_valid); end
        out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        logic [4:0] opcs[6];
        opcs = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b11111, 5'b10000};
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            w[31:27] = opcs[$urandom_range(0, 5)];
            if (w[31:27] == 5'b01000) w[26:22] = 5'd0;
            send(w, 1'b1);
        end
        drain();
        @(negedge clock);
        checks++;
        if (illegal_cnt !== 16'(exp_illegal) || stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL b2b_counters: got %0d/%0d, required %0d/%0d",
                               illegal_cnt, stall_cnt, exp_illegal, exp_stall);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_illegal();
        test_alu_decode();
        test_addi_sext();
        test_load_use();
        test_hazard_backpressure();
        test_backpressure();
        test_flush();
        test_back_to_back();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
